// File: rtl/debounce_pkg.sv
// debounce_pkg
// Shared defaults and helpers for the multi-channel push-button conditioner.
// Holds the default parameter values used by debounce_multi and
// debounce_channel, plus a width helper for the per-channel counters.
package debounce_pkg;

  localparam int DEF_N_CH              = 4;
  localparam int DEF_SYNC_STAGES       = 2;
  localparam int DEF_DEBOUNCE_CYCLES   = 2;
  localparam int DEF_ACTIVE_LOW        = 0;
  localparam int DEF_LONG_PRESS_CYCLES = 8;
  localparam int DEF_REPEAT_CYCLES     = 2;

  // Number of bits needed to hold values 0..n-1. Never returns less than 1
  // so a degenerate counter still has a legal vector width.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel
// One push-button channel: input synchroniser, optional polarity inversion,
// consecutive-sample debounce, press/release pulses and long-press/auto-repeat.
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-high reset
//   noisy_in       raw button level, asynchronous to clk
//   stable_out     debounced pressed level (1 = pressed)
//   press_pulse    1-cycle pulse on accepted 0->1 of stable_out
//   release_pulse  1-cycle pulse on accepted 1->0 of stable_out
//   long_pulse     1-cycle pulse LONG_PRESS_CYCLES after press_pulse
//   repeat_pulse   1-cycle pulse every REPEAT_CYCLES after long_pulse
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES       = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int ACTIVE_LOW        = DEF_ACTIVE_LOW,
  parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
  parameter int REPEAT_CYCLES     = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic noisy_in,
  output logic stable_out,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES + 1);
  localparam int HW = cnt_width(LONG_PRESS_CYCLES + REPEAT_CYCLES + 1);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] LONG_PRE  = HW'(LONG_PRESS_CYCLES - 1);
  localparam logic [HW-1:0] LONG_VAL  = HW'(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0] WRAP_PRE  = HW'(LONG_PRESS_CYCLES + REPEAT_CYCLES - 1);
  localparam logic          INVERT    = (ACTIVE_LOW != 0);
  localparam logic          REPEAT_EN = (REPEAT_CYCLES > 0);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DW-1:0]          deb_cnt_q, deb_cnt_d;
  logic [HW-1:0]          hold_cnt_q, hold_cnt_d;
  logic                   stable_q, stable_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   long_q, long_d;
  logic                   repeat_q, repeat_d;
  logic                   samp;

  assign samp = sync_q[SYNC_STAGES-1] ^ INVERT;

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], noisy_in};
    deb_cnt_d  = deb_cnt_q;
    stable_d   = stable_q;
    hold_cnt_d = hold_cnt_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;
    repeat_d   = 1'b0;

    if (samp == stable_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DEB_LAST) begin
      stable_d  = samp;
      deb_cnt_d = '0;
      press_d   = samp;
      release_d = ~samp;
    end else begin
      deb_cnt_d = deb_cnt_q + DW'(1);
    end

    // Hold timing only advances while the level stays pressed; a release on
    // this edge wins so no long/repeat pulse can accompany it.
    if (!stable_q || release_d) begin
      hold_cnt_d = '0;
    end else if (REPEAT_EN && (hold_cnt_q == WRAP_PRE)) begin
      hold_cnt_d = LONG_VAL;
      repeat_d   = 1'b1;
    end else if (!REPEAT_EN && (hold_cnt_q == LONG_VAL)) begin
      hold_cnt_d = hold_cnt_q;
    end else begin
      hold_cnt_d = hold_cnt_q + HW'(1);
      long_d     = (hold_cnt_q == LONG_PRE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q     <= '0;
      deb_cnt_q  <= '0;
      hold_cnt_q <= '0;
      stable_q   <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
      repeat_q   <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      deb_cnt_q  <= deb_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      stable_q   <= stable_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
      repeat_q   <= repeat_d;
    end
  end

  assign stable_out    = stable_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;

endmodule

// File: rtl/debounce_multi.sv
// debounce_multi
// Multi-channel push-button conditioner for the clock front panel. Each bit
// of noisy_in gets its own fully independent debounce_channel.
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-high reset
//   noisy_in       raw button levels [N_CH], asynchronous to clk
//   stable_out     debounced pressed levels [N_CH]
//   press_pulse    1-cycle pulses on accepted presses [N_CH]
//   release_pulse  1-cycle pulses on accepted releases [N_CH]
//   long_pulse     1-cycle pulses on long press [N_CH]
//   repeat_pulse   1-cycle auto-repeat pulses while held [N_CH]
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int N_CH              = DEF_N_CH,
  parameter int SYNC_STAGES       = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int ACTIVE_LOW        = DEF_ACTIVE_LOW,
  parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
  parameter int REPEAT_CYCLES     = DEF_REPEAT_CYCLES
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] noisy_in,
  output logic [N_CH-1:0] stable_out,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] long_pulse,
  output logic [N_CH-1:0] repeat_pulse
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES      (SYNC_STAGES),
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .ACTIVE_LOW       (ACTIVE_LOW),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
      .REPEAT_CYCLES    (REPEAT_CYCLES)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .noisy_in     (noisy_in[g]),
      .stable_out   (stable_out[g]),
      .press_pulse  (press_pulse[g]),
      .release_pulse(release_pulse[g]),
      .long_pulse   (long_pulse[g]),
      .repeat_pulse (repeat_pulse[g])
    );
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: main instance (active-high, 4 channels) plus a
// one-channel active-low instance sharing clock and reset.
module tb_debounce_multi;

  localparam int N    = 4;
  localparam int SYNC = 2;
  localparam int DEB  = 3;
  localparam int LP   = 8;
  localparam int RP   = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] noisy_in = '0;
  logic [N-1:0] stable_out, press_pulse, release_pulse, long_pulse, repeat_pulse;
  logic [0:0]   noisy_al = 1'b1;
  logic [0:0]   stable_al, press_al, release_al, long_al, repeat_al;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  debounce_multi #(
    .N_CH(N), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .ACTIVE_LOW(0),
    .LONG_PRESS_CYCLES(LP), .REPEAT_CYCLES(RP)
  ) dut (
    .clk(clk), .reset(reset), .noisy_in(noisy_in), .stable_out(stable_out),
    .press_pulse(press_pulse), .release_pulse(release_pulse),
    .long_pulse(long_pulse), .repeat_pulse(repeat_pulse)
  );

  debounce_multi #(
    .N_CH(1), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .ACTIVE_LOW(1),
    .LONG_PRESS_CYCLES(LP), .REPEAT_CYCLES(RP)
  ) dut_al (
    .clk(clk), .reset(reset), .noisy_in(noisy_al), .stable_out(stable_al),
    .press_pulse(press_al), .release_pulse(release_al),
    .long_pulse(long_al), .repeat_pulse(repeat_al)
  );

  // Reference model: stable flips when the last DEB synchronised samples all
  // disagree with it; hold events are derived from cycles elapsed since press.
  typedef struct packed {
    logic [31:0] hist;
    logic [31:0] vld;
    logic        stable;
    logic        press;
    logic        rel;
    logic        lng;
    logic        rep;
    int          elapsed;
  } mdl_t;

  mdl_t m [N];
  mdl_t m_al;

  function automatic mdl_t mdl_reset(input logic al);
    mdl_t r;
    r = '0;
    // the synchroniser flops reset to 0 and are seen as real samples
    for (int i = 0; i < SYNC; i++) begin
      r.hist[i] = al;
      r.vld[i]  = 1'b1;
    end
    return r;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t mi, input logic raw, input logic al);
    mdl_t r;
    logic flip;
    r = mi;
    r.hist = {r.hist[30:0], raw ^ al};
    r.vld  = {r.vld[30:0], 1'b1};
    flip = 1'b1;
    for (int i = 0; i < DEB; i++)
      if (!r.vld[SYNC+i] || (r.hist[SYNC+i] == r.stable)) flip = 1'b0;
    r.press = 1'b0; r.rel = 1'b0; r.lng = 1'b0; r.rep = 1'b0;
    if (flip) begin
      r.stable = ~r.stable;
      if (r.stable) begin r.press = 1'b1; r.elapsed = 0; end
      else r.rel = 1'b1;
    end else if (r.stable) begin
      r.elapsed = r.elapsed + 1;
      if (r.elapsed == LP) r.lng = 1'b1;
      else if (RP > 0 && r.elapsed > LP && ((r.elapsed - LP) % RP) == 0) r.rep = 1'b1;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset_all();
    for (int c = 0; c < N; c++) m[c] = mdl_reset(1'b0);
    m_al = mdl_reset(1'b1);
  endtask

  task automatic check_zero(input string name);
    chk({name, "_main"}, 32'({stable_out, press_pulse, release_pulse, long_pulse, repeat_pulse}), 32'd0);
    chk({name, "_al"}, 32'({stable_al, press_al, release_al, long_al, repeat_al}), 32'd0);
  endtask

  task automatic tick();
    logic [N-1:0] es, ep, er, el, eq;
    @(posedge clk);
    for (int c = 0; c < N; c++) m[c] = mdl_step(m[c], noisy_in[c], 1'b0);
    m_al = mdl_step(m_al, noisy_al[0], 1'b1);
    #1;
    for (int c = 0; c < N; c++) begin
      es[c] = m[c].stable; ep[c] = m[c].press; er[c] = m[c].rel;
      el[c] = m[c].lng;    eq[c] = m[c].rep;
    end
    chk("stable",  32'(stable_out),    32'(es));
    chk("press",   32'(press_pulse),   32'(ep));
    chk("release", 32'(release_pulse), 32'(er));
    chk("long",    32'(long_pulse),    32'(el));
    chk("repeat",  32'(repeat_pulse),  32'(eq));
    chk("al_out", 32'({stable_al, press_al, release_al, long_al, repeat_al}),
        32'({m_al.stable, m_al.press, m_al.rel, m_al.lng, m_al.rep}));
  endtask

  task automatic wait_press(input int ch, input int budget, output int waited);
    waited = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (press_pulse[ch]) begin waited = i; break; end
    end
    n_cmp++;
    if (waited < 0) begin
      n_err++;
      $display("FAIL wait_press ch%0d: no press within %0d cycles", ch, budget);
    end
  endtask

  typedef struct packed {
    logic [N-1:0] raw;
    logic [N-1:0] stable;
    logic [N-1:0] press;
    logic [N-1:0] rel;
  } vec_t;

  vec_t vt [8];

  initial begin
    int w, npress, nrel, nlong, pedge, nstab;
    logic [7:0] pat;
    int left [N];

    // clean-press table: ch0 goes high before edge 0 and is held
    for (int i = 0; i < 8; i++) begin
      vt[i].raw    = 4'b0001;
      vt[i].stable = (i >= 4) ? 4'b0001 : 4'b0000;
      vt[i].press  = (i == 4) ? 4'b0001 : 4'b0000;
      vt[i].rel    = 4'b0000;
    end

    #2 reset = 1'b1;
    #1 check_zero("reset_async");
    repeat (3) @(posedge clk);
    #1 check_zero("reset_hold");
    reset = 1'b0;
    model_reset_all();

    // 1: clean press
    for (int i = 0; i < 8; i++) begin
      noisy_in = vt[i].raw;
      tick();
      chk($sformatf("tbl_stable[%0d]", i), 32'(stable_out), 32'(vt[i].stable));
      chk($sformatf("tbl_press[%0d]", i), 32'(press_pulse), 32'(vt[i].press));
      chk($sformatf("tbl_release[%0d]", i), 32'(release_pulse), 32'(vt[i].rel));
    end
    noisy_in[0] = 1'b0;
    repeat (8) tick();

    // 2: bounce rejection on ch1
    pat = 8'b1110_1101;
    npress = 0; nrel = 0; pedge = -1;
    for (int j = 0; j < 14; j++) begin
      noisy_in[1] = (j < 8) ? pat[j] : 1'b1;
      tick();
      if (press_pulse[1]) begin npress++; pedge = j; end
      if (release_pulse[1]) nrel++;
    end
    chk("bounce_npress", 32'(npress), 32'd1);
    chk("bounce_edge", 32'(pedge), 32'd9);
    chk("bounce_nrel", 32'(nrel), 32'd0);
    noisy_in[1] = 1'b0;
    repeat (10) tick();

    // 3: long press + repeat on ch2
    noisy_in[2] = 1'b1;
    wait_press(2, 20, w);
    chk("lp_latency", 32'(w), 32'd4);
    for (int k = 1; k <= 30; k++) begin
      tick();
      chk($sformatf("lp_long[%0d]", k), 32'(long_pulse[2]), 32'(k == 8));
      chk($sformatf("lp_rep[%0d]", k), 32'(repeat_pulse[2]),
          32'(k == 12 || k == 16 || k == 20 || k == 24 || k == 28));
    end
    noisy_in[2] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk($sformatf("lp_rel[%0d]", k), 32'(release_pulse[2]), 32'(k == 4));
      if (k >= 4)
        chk($sformatf("lp_quiet[%0d]", k), 32'({long_pulse[2], repeat_pulse[2]}), 32'd0);
    end

    // 4: short press on ch3
    npress = 0; nrel = 0; nlong = 0; nstab = 0;
    noisy_in[3] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (k == 5) noisy_in[3] = 1'b0;
      tick();
      npress += int'(press_pulse[3]);
      nrel   += int'(release_pulse[3]);
      nlong  += int'(long_pulse[3] | repeat_pulse[3]);
      nstab  += int'(stable_out[3]);
    end
    chk("short_npress", 32'(npress), 32'd1);
    chk("short_nrel", 32'(nrel), 32'd1);
    chk("short_nlong", 32'(nlong), 32'd0);
    chk("short_nstable", 32'(nstab), 32'd5);

    // 5: reset mid-hold on ch2
    noisy_in[2] = 1'b1;
    wait_press(2, 20, w);
    repeat (10) tick();
    reset = 1'b1;
    #1 check_zero("midhold_async");
    repeat (2) @(posedge clk);
    #1 check_zero("midhold_held");
    reset = 1'b0;
    model_reset_all();
    npress = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk($sformatf("rst_press[%0d]", k), 32'(press_pulse[2]), 32'(k == 4));
      chk($sformatf("rst_long[%0d]", k), 32'(long_pulse[2]), 32'(k == 12));
      npress += int'(press_al[0]);
    end
    noisy_in[2] = 1'b0;
    repeat (8) tick();

    // 6: active-low instance idle high since reset, then pressed
    chk("al_idle_npress", 32'(npress), 32'd0);
    noisy_al = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("al_press[%0d]", k), 32'(press_al[0]), 32'(k == 4));
    end
    noisy_al = 1'b1;
    repeat (8) tick();

    // randomized run against the model
    for (int c = 0; c < N; c++) left[c] = 1;
    for (int t = 0; t < 3000; t++) begin
      for (int c = 0; c < N; c++) begin
        left[c]--;
        if (left[c] <= 0) begin
          noisy_in[c] = ~noisy_in[c];
          left[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 25))
                                                : int'($urandom_range(1, 5));
        end
      end
      if ($urandom_range(0, 7) == 0) noisy_al = ~noisy_al;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
